// File: rtl/id_hazard_req.sv
// ID-stage hazard request generator: load-use and multi-cycle multiply stalls,
// redirect flush, and a saturating count of stalled cycles.
module id_hazard_req #(
   parameter int REG_ADDR_W = 5,
   parameter int MUL_LAT    = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_idValid,
   input  logic [REG_ADDR_W-1:0] io_idRs1,
   input  logic [REG_ADDR_W-1:0] io_idRs2,
   input  logic                  io_idUseRs1,
   input  logic                  io_idUseRs2,
   input  logic [REG_ADDR_W-1:0] io_idRd,
   input  logic                  io_idWritesRd,
   input  logic                  io_idIsLoad,
   input  logic                  io_idIsMul,
   input  logic                  io_idRedirect,
   output logic                  io_stallReqOfID,
   output logic                  io_flushReqOfID,
   output logic [CNT_W-1:0]      io_stallCycles
);

   localparam int SLOTS = 3;
   localparam int MCNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
   localparam logic [MCNT_W-1:0] MUL_RELOAD = MCNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);
   localparam bit MUL_STALLS = (MUL_LAT >= 2);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  writesRd;
      logic                  isLoad;
   } slotT;

   typedef enum logic {IDLE, BUSY} mulStateT;

   // Index 0 = EXE, 1 = MEM, 2 = WB.
   slotT             shadow [SLOTS];
   slotT             idSlot;
   mulStateT         mulState;
   logic [MCNT_W-1:0] mulCnt;
   logic [CNT_W-1:0] stallCnt;

   logic exeLoadDst;
   logic rs1Hit;
   logic rs2Hit;
   logic loadUse;
   logic mulStart;
   logic mulHold;
   logic stallRaw;

   always_comb begin
      idSlot          = '0;
      idSlot.valid    = io_idValid;
      idSlot.rd       = io_idRd;
      idSlot.writesRd = io_idWritesRd;
      idSlot.isLoad   = io_idIsLoad;
   end

   // A load writing x0 never produces a usable value, so it never stalls.
   assign exeLoadDst = shadow[0].valid & shadow[0].isLoad & shadow[0].writesRd
                       & (shadow[0].rd != '0);
   assign rs1Hit     = io_idUseRs1 & (io_idRs1 == shadow[0].rd);
   assign rs2Hit     = io_idUseRs2 & (io_idRs2 == shadow[0].rd);
   assign loadUse    = io_idValid & exeLoadDst & (rs1Hit | rs2Hit);

   assign mulStart = MUL_STALLS & io_idValid & io_idIsMul & ~loadUse;
   assign mulHold  = (mulState == BUSY) & (mulCnt != '0);
   assign stallRaw = loadUse | ((mulState == IDLE) & mulStart) | mulHold;

   assign io_stallReqOfID = ~reset & stallRaw;
   assign io_flushReqOfID = ~reset & io_idValid & io_idRedirect & ~stallRaw;
   assign io_stallCycles  = stallCnt;

   // EXE takes a bubble whenever ID is held, matching the controller's EXE flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         shadow[0] <= '0;
      end else if (!io_stallReqOfID && io_idValid) begin
         shadow[0] <= idSlot;
      end else begin
         shadow[0] <= '0;
      end
   end

   generate
      for (genvar gi = 1; gi < SLOTS; gi++) begin : gShadow
         always_ff @(posedge clock) begin
            if (reset) begin
               shadow[gi] <= '0;
            end else begin
               shadow[gi] <= shadow[gi-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         mulState <= IDLE;
         mulCnt   <= '0;
      end else begin
         case (mulState)
            IDLE: begin
               if (mulStart) begin
                  mulState <= BUSY;
                  mulCnt   <= MUL_RELOAD;
               end
            end
            BUSY: begin
               if (mulCnt != '0) begin
                  mulCnt <= mulCnt - 1'b1;
               end else begin
                  mulState <= IDLE;
               end
            end
            default: begin
               mulState <= IDLE;
               mulCnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stallCnt <= '0;
      end else if (io_stallReqOfID && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

endmodule
